// File: rtl/switch_word_loader_if.sv
// switch_word_loader_if: switch/button inputs and committed-word outputs of the word loader
interface switch_word_loader_if;
  logic [7:0]  sw_data;
  logic [1:0]  sw_sel;
  logic        key_load_l;
  logic        key_go_l;
  logic [31:0] word;
  logic        word_valid;
  logic [3:0]  staged_mask;
  logic [7:0]  preview;
  modport master (output sw_data, sw_sel, key_load_l, key_go_l, input word, word_valid, staged_mask, preview);
  modport slave  (input sw_data, sw_sel, key_load_l, key_go_l, output word, word_valid, staged_mask, preview);
endinterface

// File: rtl/switch_word_loader.sv
// switch_word_loader: synchronizes and debounces switches/keys and assembles a 32-bit word byte by byte
module switch_word_loader #(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input logic clk,
  input logic rst_l,
  switch_word_loader_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic {IDLE, FILLING} state_t;
  state_t      r_state;
  logic [7:0]  r_data_s1, r_data_s2;
  logic [1:0]  r_sel_s1, r_sel_s2;
  logic [1:0]  r_key_s1, r_key_s2;
  logic [31:0] r_stage, r_word, w_stage;
  logic [3:0]  r_mask, w_mask;
  logic        r_valid;
  logic        w_ld, w_go;
  // two-flop synchronizers; keys idle high (released)
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_data_s1 <= '0;
      r_data_s2 <= '0;
      r_sel_s1  <= '0;
      r_sel_s2  <= '0;
      r_key_s1  <= 2'b11;
      r_key_s2  <= 2'b11;
    end else begin
      r_data_s1 <= bus.sw_data;
      r_data_s2 <= r_data_s1;
      r_sel_s1  <= bus.sw_sel;
      r_sel_s2  <= r_sel_s1;
      r_key_s1  <= {bus.key_go_l, bus.key_load_l};
      r_key_s2  <= r_key_s1;
    end
  end
  for (genvar k = 0; k < 2; k++) begin : g_key
    logic          r_deb, r_deb_q, r_ev;
    logic [CW-1:0] r_cnt;
    // debounce: level flips after DEBOUNCE_CYCLES disagreeing cycles; press pulse one cycle after the 1->0 flip
    always_ff @(posedge clk) begin
      if (!rst_l) begin
        r_deb   <= 1'b1;
        r_deb_q <= 1'b1;
        r_ev    <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_deb_q <= r_deb;
        r_ev    <= r_deb_q & ~r_deb;
        if (r_key_s2[k] == r_deb) r_cnt <= '0;
        else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb <= ~r_deb;
          r_cnt <= '0;
        end else r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign w_ld = g_key[0].r_ev;
  assign w_go = g_key[1].r_ev;
  // staging with this cycle's load merged in, so a simultaneous go commits the new byte
  always_comb begin
    w_stage = r_stage;
    w_mask  = r_mask;
    if (w_ld) begin
      w_stage[{r_sel_s2, 3'b000} +: 8] = r_data_s2;
      w_mask[r_sel_s2] = 1'b1;
    end
  end
  // loader FSM: IDLE while nothing staged, FILLING once any lane is written
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state <= IDLE;
      r_stage <= '0;
      r_mask  <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_go && (w_ld || r_state == FILLING)) begin
        r_word  <= w_stage;
        r_valid <= 1'b1;
        r_stage <= '0;
        r_mask  <= '0;
        r_state <= IDLE;
      end else if (w_ld) begin
        r_stage <= w_stage;
        r_mask  <= w_mask;
        r_state <= FILLING;
      end
    end
  end
  assign bus.word        = r_word;
  assign bus.word_valid  = r_valid;
  assign bus.staged_mask = r_mask;
  assign bus.preview     = r_stage[{r_sel_s2, 3'b000} +: 8];
endmodule

// File: tb/tb_switch_word_loader.sv
// tb_switch_word_loader: randomized and directed checks of the word loader against a lane-level model
module tb_switch_word_loader;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;
  logic [7:0]  m_stage [4];
  logic [3:0]  m_mask;
  logic [31:0] m_word;
  switch_word_loader_if bus();
  switch_word_loader #(.DEBOUNCE_CYCLES(4)) dut (.clk(clk), .rst_l(rst_l), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.word_valid) begin
      n_valid++;
      check("wv_consecutive", {31'd0, prev_valid}, 32'd0);
    end
    prev_valid = bus.word_valid;
  end
  function automatic logic [31:0] packed_stage();
    return {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_stage[i] = 8'h00;
    m_mask = 4'h0;
  endtask
  task automatic press(input bit ld, input bit go, input logic [1:0] sel, input logic [7:0] data);
    int  v0;
    bit  commit;
    bus.sw_sel  = sel;
    bus.sw_data = data;
    repeat (3) @(negedge clk);
    v0 = n_valid;
    bus.key_load_l = !ld;
    bus.key_go_l   = !go;
    repeat (8) @(negedge clk);
    bus.key_load_l = 1'b1;
    bus.key_go_l   = 1'b1;
    repeat (10) @(negedge clk);
    if (ld) begin
      m_stage[sel] = data;
      m_mask[sel]  = 1'b1;
    end
    commit = go && (m_mask != 4'h0);
    if (commit) begin
      m_word = packed_stage();
      model_clear();
    end
    check("pulses", n_valid - v0, {31'd0, commit});
    check("mask", {28'd0, bus.staged_mask}, {28'd0, m_mask});
    check("word", bus.word, m_word);
    check("preview", {24'd0, bus.preview}, {24'd0, m_stage[sel]});
  endtask
  initial begin
    logic [7:0] lanes [4];
    logic [1:0] s;
    logic [3:0] mask0;
    bus.sw_data = 8'h00;
    bus.sw_sel = 2'd0;
    bus.key_load_l = 1'b1;
    bus.key_go_l = 1'b1;
    model_clear();
    m_word = 32'h0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("reset_idle", {bus.word[23:0], bus.preview}, 32'h0);
      check("reset_flags", {26'd0, bus.word[31:24] != 8'h00, bus.word_valid, bus.staged_mask}, 32'h0);
    end
    lanes[0] = 8'hEF; lanes[1] = 8'hBE; lanes[2] = 8'hAD; lanes[3] = 8'hDE;
    for (int i = 0; i < 4; i++) press(1, 0, 2'(i), lanes[i]);
    check("mask_full", {28'd0, bus.staged_mask}, 32'hF);
    press(0, 1, 2'd0, 8'h00);
    check("deadbeef", bus.word, 32'hDEADBEEF);
    bus.sw_sel = 2'd1;
    bus.sw_data = 8'h3C;
    repeat (3) @(negedge clk);
    for (int r = 0; r < 10; r++) begin
      bus.key_load_l = 1'b0;
      repeat (3) @(negedge clk);
      bus.key_load_l = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("glitch_mask", {28'd0, bus.staged_mask}, 32'h0);
    mask0 = bus.staged_mask;
    bus.key_load_l = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("latency_early", {28'd0, bus.staged_mask}, {28'd0, mask0});
    @(posedge clk);
    #1 check("latency_edge7", {28'd0, bus.staged_mask}, 32'h2);
    @(negedge clk);
    bus.key_load_l = 1'b1;
    repeat (12) @(negedge clk);
    m_stage[1] = 8'h3C;
    m_mask = 4'h2;
    press(0, 1, 2'd1, 8'h00);
    check("glitch_word", bus.word, 32'h00003C00);
    press(1, 0, 2'd2, 8'h12);
    press(0, 1, 2'd2, 8'h00);
    check("lane2_word", bus.word, 32'h00120000);
    press(0, 1, 2'd2, 8'h00);
    check("idle_go_word", bus.word, 32'h00120000);
    press(1, 0, 2'd1, 8'h55);
    press(1, 0, 2'd1, 8'hAA);
    check("reload_preview", {24'd0, bus.preview}, 32'hAA);
    press(0, 1, 2'd1, 8'h00);
    check("reload_word", {24'd0, bus.word[15:8]}, 32'hAA);
    press(1, 1, 2'd3, 8'h77);
    check("merge_word", bus.word, 32'h77000000);
    check("merge_mask", {28'd0, bus.staged_mask}, 32'h0);
    press(1, 0, 2'd0, 8'h11);
    press(1, 0, 2'd2, 8'h22);
    begin
      int v0;
      v0 = n_valid;
      rst_l = 1'b0;
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      repeat (3) @(negedge clk);
      model_clear();
      m_word = 32'h0;
      check("rst_mask", {28'd0, bus.staged_mask}, 32'h0);
      check("rst_pulse", n_valid - v0, 32'd0);
    end
    press(1, 0, 2'd1, 8'h01);
    press(0, 1, 2'd1, 8'h00);
    check("post_rst_word", bus.word, 32'h00000100);
    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 9);
      press(op < 6 || op == 9, op >= 6, 2'($urandom_range(0, 3)), 8'($urandom));
      s = 2'($urandom_range(0, 3));
      bus.sw_sel = s;
      repeat (3) @(negedge clk);
      check("rand_preview", {24'd0, bus.preview}, {24'd0, m_stage[s]});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
